// File: rtl/prefetch_fetch_unit.sv
// Instruction prefetch unit: fetches sequential words into a small FIFO,
// handles redirects (flush + refetch) and discards responses to abandoned
// requests. Optional macro FETCH_PERF_CNT_EN adds fetch_discard_cnt_o, a
// count of memory responses dropped because of a redirect.

`ifndef RISCV_ADDR_WIDTH
`define RISCV_ADDR_WIDTH 32
`endif
`ifndef RISCV_WORD_WIDTH
`define RISCV_WORD_WIDTH 32
`endif

module prefetch_fetch_unit #(
  parameter logic [`RISCV_ADDR_WIDTH-1:0] BOOT_ADDRESS = 32'h0,
  parameter int unsigned                  DEPTH        = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         req_i,
  input  logic                         retire_inst_i,
  input  logic                         target_valid_i,
  input  logic [`RISCV_ADDR_WIDTH-1:0] target_addr_i,
  output logic [`RISCV_WORD_WIDTH-1:0] instr_o,
  output logic [`RISCV_ADDR_WIDTH-1:0] instr_addr_o,
  output logic                         instr_valid_o,
  output logic                         imem_valid_o,
  input  logic                         imem_ready_i,
  output logic [`RISCV_ADDR_WIDTH-1:0] imem_addr_o,
  output logic [`RISCV_WORD_WIDTH-1:0] imem_wdata_o,
  output logic [3:0]                   imem_we_o,
  input  logic [`RISCV_WORD_WIDTH-1:0] imem_rdata_i
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]                  fetch_discard_cnt_o
`endif
);

  localparam int unsigned AW = `RISCV_ADDR_WIDTH;
  localparam int unsigned WW = `RISCV_WORD_WIDTH;
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    DISCARD = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic          imem_valid_q;
  logic [AW-1:0] fpc_q, fpc_d;
  logic [AW-1:0] req_addr_q, req_addr_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [AW-1:0] addr_mem_q [DEPTH];
  logic [WW-1:0] data_mem_q [DEPTH];

  logic          push, pop, flush, can_issue, issue_en;
  logic [AW-1:0] issue_addr, target_aligned;

  assign instr_valid_o = (count_q != '0);
  assign instr_o       = instr_valid_o ? data_mem_q[rd_ptr_q] : '0;
  assign instr_addr_o  = instr_valid_o ? addr_mem_q[rd_ptr_q] : '0;
  assign imem_valid_o  = imem_valid_q;
  assign imem_addr_o   = req_addr_q;
  assign imem_wdata_o  = '0;
  assign imem_we_o     = '0;

  // Next-state decode: occupancy forecast, then the single issue decision.
  always_comb begin
    target_aligned = target_addr_i & ~AW'(3);
    pop        = retire_inst_i & instr_valid_o;
    push       = (state_q == BUSY) & imem_ready_i & ~target_valid_i;
    flush      = target_valid_i;
    count_d    = flush ? '0 : count_q + CW'(push) - CW'(pop);
    can_issue  = req_i & (count_d < CW'(DEPTH));
    issue_en   = 1'b0;
    issue_addr = fpc_q;
    state_d    = state_q;
    fpc_d      = fpc_q;
    req_addr_d = req_addr_q;
    case (state_q)
      IDLE: begin
        if (target_valid_i) begin
          issue_en   = 1'b1;
          issue_addr = target_aligned;
        end else if (can_issue) begin
          issue_en   = 1'b1;
        end
      end
      BUSY: begin
        if (imem_ready_i) begin
          if (target_valid_i) begin
            issue_en   = 1'b1;
            issue_addr = target_aligned;
          end else if (can_issue) begin
            issue_en   = 1'b1;
          end else begin
            state_d    = IDLE;
          end
        end else if (target_valid_i) begin
          // Request still in flight: remember target, drop its response later.
          fpc_d   = target_aligned;
          state_d = DISCARD;
        end
      end
      DISCARD: begin
        if (imem_ready_i) begin
          issue_en   = 1'b1;
          issue_addr = target_valid_i ? target_aligned : fpc_q;
        end else if (target_valid_i) begin
          fpc_d = target_aligned;
        end
      end
      default: state_d = IDLE;
    endcase
    if (issue_en) begin
      state_d    = BUSY;
      req_addr_d = issue_addr;
      fpc_d      = issue_addr + AW'(4);
    end
  end

  // Control state, registered memory strobe and FIFO pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      imem_valid_q <= 1'b0;
      fpc_q        <= BOOT_ADDRESS;
      req_addr_q   <= BOOT_ADDRESS;
      count_q      <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
    end else begin
      state_q      <= state_d;
      imem_valid_q <= (state_d != IDLE);
      fpc_q        <= fpc_d;
      req_addr_q   <= req_addr_d;
      count_q      <= count_d;
      if (flush) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      end
    end
  end

  // FIFO storage; contents are don't-care while their slot is not counted.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem_q[wr_ptr_q] <= req_addr_q;
      data_mem_q[wr_ptr_q] <= imem_rdata_i;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic        drop;
  logic [31:0] discard_cnt_q;

  assign drop = imem_ready_i &
                (((state_q == BUSY) & target_valid_i) | (state_q == DISCARD));
  assign fetch_discard_cnt_o = discard_cnt_q;

  // Count responses thrown away because a redirect overtook them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    discard_cnt_q <= '0;
    else if (drop) discard_cnt_q <= discard_cnt_q + 32'd1;
  end
`endif

endmodule

// File: tb/tb_prefetch_fetch_unit.sv
// Testbench for prefetch_fetch_unit: directed scenarios plus a randomized
// phase, with a scoreboard of expected fetched words checked by a monitor.
module tb_prefetch_fetch_unit;

  localparam logic [31:0] BOOT  = 32'h100;
  localparam int          DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_i = 1'b0;
  logic        retire_inst_i = 1'b0;
  logic        target_valid_i = 1'b0;
  logic [31:0] target_addr_i = '0;
  logic [31:0] instr_o, instr_addr_o, imem_addr_o, imem_wdata_o;
  logic        instr_valid_o, imem_valid_o;
  logic        imem_ready_i = 1'b0;
  logic [3:0]  imem_we_o;
  logic [31:0] imem_rdata_i = '0;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_discard_cnt_o;
`endif

  prefetch_fetch_unit #(.BOOT_ADDRESS(BOOT), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_i          (req_i),
    .retire_inst_i  (retire_inst_i),
    .target_valid_i (target_valid_i),
    .target_addr_i  (target_addr_i),
    .instr_o        (instr_o),
    .instr_addr_o   (instr_addr_o),
    .instr_valid_o  (instr_valid_o),
    .imem_valid_o   (imem_valid_o),
    .imem_ready_i   (imem_ready_i),
    .imem_addr_o    (imem_addr_o),
    .imem_wdata_o   (imem_wdata_o),
    .imem_we_o      (imem_we_o),
    .imem_rdata_i   (imem_rdata_i)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_discard_cnt_o (fetch_discard_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Instruction memory contents as a pure function of the word address.
  function automatic logic [31:0] memfn(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  // Memory responder: 0 = driven by the test, 1 = zero-wait, 2 = random waits.
  int mem_mode = 0;
  int wait_cnt = 0;
  always @(posedge clk) begin
    #2;
    if (mem_mode != 0) begin
      if (imem_valid_o && wait_cnt == 0) begin
        imem_ready_i = 1'b1;
        imem_rdata_i = memfn(imem_addr_o);
        if (mem_mode == 2) wait_cnt = $urandom_range(0, 2);
      end else begin
        imem_ready_i = 1'b0;
        imem_rdata_i = $urandom;
        if (imem_valid_o && wait_cnt > 0) wait_cnt--;
      end
    end
  end

  // Reference model: the stream seen by the consumer is a run of consecutive
  // words starting at the last redirect target; a redirect while a request is
  // outstanding means that request's answer is thrown away.
  logic [31:0] exp_q[$];
  logic [31:0] req_log[$];
  logic [31:0] fetch_exp = BOOT;
  logic        pending = 1'b0;
  int          drops = 0;
  int          n_retired = 0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_addr = '0;

  // Monitor: compare outputs with the model, then apply the coming edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      fetch_exp  = BOOT;
      pending    = 1'b0;
      drops      = 0;
      prev_stall = 1'b0;
      chk("rst_imem_valid", 32'(imem_valid_o), 32'd0);
      chk("rst_instr_valid", 32'(instr_valid_o), 32'd0);
    end else begin
      logic do_pop;
      chk("imem_we", 32'(imem_we_o), 32'd0);
      chk("imem_wdata", imem_wdata_o, 32'd0);
`ifdef FETCH_PERF_CNT_EN
      chk("discard_cnt", fetch_discard_cnt_o, 32'(drops));
`endif
      if (prev_stall && imem_valid_o) chk("addr_stable", imem_addr_o, prev_addr);
      chk("instr_valid", 32'(instr_valid_o), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        chk("head_addr", instr_addr_o, exp_q[0]);
        chk("head_data", instr_o, memfn(exp_q[0]));
      end else begin
        chk("empty_instr", instr_o, 32'd0);
        chk("empty_addr", instr_addr_o, 32'd0);
      end
      do_pop = retire_inst_i && !target_valid_i && (exp_q.size() != 0);
      if (do_pop) begin
        void'(exp_q.pop_front());
        n_retired++;
      end
      if (imem_valid_o && imem_ready_i) begin
        req_log.push_back(imem_addr_o);
        if (target_valid_i || pending) begin
          drops++;
          pending = 1'b0;
        end else begin
          chk("fetch_addr", imem_addr_o, fetch_exp);
          chk("push_not_full", 32'(exp_q.size() < DEPTH), 32'd1);
          exp_q.push_back(fetch_exp);
          fetch_exp += 32'd4;
        end
      end
      if (target_valid_i) begin
        if (imem_valid_o && !imem_ready_i) pending = 1'b1;
        exp_q.delete();
        fetch_exp = target_addr_i & ~32'h3;
      end
      prev_stall = imem_valid_o && !imem_ready_i;
      prev_addr  = imem_addr_o;
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int r0;
    step(3);
    chk("reset_instr_o", instr_o, 32'd0);
    chk("reset_instr_addr", instr_addr_o, 32'd0);

    // Boot fetch fills the buffer, then the bus goes quiet.
    mem_mode = 1; wait_cnt = 0; req_i = 1'b1; rst_n = 1'b1;
    req_log.delete();
    step(10);
    chk("boot_nreq", 32'(req_log.size()), 32'd4);
    for (int i = 0; i < 4 && i < req_log.size(); i++)
      chk("boot_req_addr", req_log[i], BOOT + 32'(4 * i));
    chk("full_idle", 32'(imem_valid_o), 32'd0);
    chk("full_head", instr_addr_o, 32'h100);

    // One retire from full yields exactly one refill.
    req_log.delete();
    retire_inst_i = 1'b1; step(1); retire_inst_i = 1'b0;
    step(6);
    chk("refill_nreq", 32'(req_log.size()), 32'd1);
    if (req_log.size() > 0) chk("refill_addr", req_log[0], 32'h110);
    chk("refill_idle", 32'(imem_valid_o), 32'd0);
    chk("refill_head", instr_addr_o, 32'h104);

    // Redirect while the memory stalls: request held, answer dropped.
    mem_mode = 0; imem_ready_i = 1'b0;
    retire_inst_i = 1'b1; step(1); retire_inst_i = 1'b0;
    chk("stall_addr0", imem_addr_o, 32'h114);
    target_valid_i = 1'b1; target_addr_i = 32'h203; step(1);
    target_valid_i = 1'b0;
    chk("discard_valid", 32'(imem_valid_o), 32'd1);
    chk("discard_addr1", imem_addr_o, 32'h114);
    chk("discard_flush", 32'(instr_valid_o), 32'd0);
    step(1);
    chk("discard_addr2", imem_addr_o, 32'h114);
    imem_ready_i = 1'b1; imem_rdata_i = 32'hDEADBEEF; step(1);
    imem_ready_i = 1'b0;
    chk("after_discard_addr", imem_addr_o, 32'h200);
    chk("after_discard_empty", 32'(instr_valid_o), 32'd0);
`ifdef FETCH_PERF_CNT_EN
    chk("discard_cnt_one", fetch_discard_cnt_o, 32'd1);
`endif
    mem_mode = 1; wait_cnt = 0;
    step(2);
    chk("target_head", instr_addr_o, 32'h200);

    // Redirect, response and retire in the same cycle.
    step(8);
    retire_inst_i = 1'b1; step(1);
    target_valid_i = 1'b1; target_addr_i = 32'h300; step(1);
    target_valid_i = 1'b0; retire_inst_i = 1'b0;
    chk("triple_empty", 32'(instr_valid_o), 32'd0);
    chk("triple_addr", imem_addr_o, 32'h300);
`ifdef FETCH_PERF_CNT_EN
    chk("discard_cnt_two", fetch_discard_cnt_o, 32'd2);
`endif
    step(1);
    chk("triple_head", instr_addr_o, 32'h300);

    // Address wrap at the top of memory, plus redirect latency.
    step(8);
    target_valid_i = 1'b1; target_addr_i = 32'hFFFF_FFFE; step(1);
    target_valid_i = 1'b0;
    chk("wrap_req0", imem_addr_o, 32'hFFFF_FFFC);
    chk("wrap_valid", 32'(imem_valid_o), 32'd1);
    chk("lat_not_yet", 32'(instr_valid_o), 32'd0);
    step(1);
    chk("wrap_req1", imem_addr_o, 32'h0);
    chk("lat_valid", 32'(instr_valid_o), 32'd1);
    chk("lat_head", instr_addr_o, 32'hFFFF_FFFC);

    // Reset during an outstanding request; a late ready is ignored.
    step(8);
    mem_mode = 0; imem_ready_i = 1'b0;
    target_valid_i = 1'b1; target_addr_i = 32'h400; step(1);
    target_valid_i = 1'b0;
    chk("pre_rst_addr", imem_addr_o, 32'h400);
    step(1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_imem_valid", 32'(imem_valid_o), 32'd0);
    chk("async_rst_instr_valid", 32'(instr_valid_o), 32'd0);
    chk("async_rst_instr", instr_o, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1; imem_ready_i = 1'b1; imem_rdata_i = 32'hBAD0BAD0;
    @(posedge clk);
    #1 imem_ready_i = 1'b0;
    chk("post_rst_addr", imem_addr_o, BOOT);
    chk("post_rst_valid", 32'(imem_valid_o), 32'd1);
    chk("post_rst_no_push", 32'(instr_valid_o), 32'd0);
    mem_mode = 1; wait_cnt = 0;
    step(2);
    chk("post_rst_head", instr_addr_o, BOOT);

    // Streaming: one instruction per cycle with continuous retire.
    target_valid_i = 1'b1; target_addr_i = 32'h500; retire_inst_i = 1'b1; step(1);
    target_valid_i = 1'b0;
    step(3);
    r0 = n_retired;
    step(20);
    chk("throughput", 32'(n_retired - r0), 32'd20);

    // Random traffic against the model.
    mem_mode = 2; wait_cnt = 0;
    r0 = n_retired;
    for (int i = 0; i < 3000; i++) begin
      req_i          = ($urandom_range(0, 9) != 0);
      retire_inst_i  = ($urandom_range(0, 9) < 7);
      target_valid_i = ($urandom_range(0, 39) == 0);
      target_addr_i  = $urandom;
      step(1);
    end
    target_valid_i = 1'b0; retire_inst_i = 1'b0;
    step(4);
    chk("random_progress", 32'((n_retired - r0) > 300), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
